// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment encode/decode path.
//
// Contents:
//   SEG_0 .. SEG_9  legal segment patterns, bit order abcdefg (bit6 = a, bit0 = g)
//   SEG_BLANK       all segments off
//   CNT_W           width of the dwell stability counter
//   dwell_state_t   states of the digit dwell FSM
//   dwell_t         dwell FSM state plus its counter, kept together so the
//                   whole FSM condition is visible as one signal
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_4     = 7'b0110011;
    localparam logic [6:0] SEG_5     = 7'b1011011;
    localparam logic [6:0] SEG_6     = 7'b1011111;
    localparam logic [6:0] SEG_7     = 7'b1110000;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1111011;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_HOLD  = 2'd2
    } dwell_state_t;

    typedef struct packed {
        dwell_state_t     state;
        logic [CNT_W-1:0] count;
    } dwell_t;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational 7-segment pattern to BCD decoder.
//
// Ports:
//   seg_i      [6:0]  segment pattern, abcdefg, active-high
//   bcd_o      [3:0]  decoded digit, 4'hF for any unrecognised pattern
//   invalid_o         1 when seg_i is not one of the ten legal digit patterns
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] seg_i,
    output logic [3:0] bcd_o,
    output logic       invalid_o
);

    always_comb begin
        bcd_o     = 4'hF;
        invalid_o = 1'b0;
        case (seg_i)
            SEG_0:   bcd_o = 4'd0;
            SEG_1:   bcd_o = 4'd1;
            SEG_2:   bcd_o = 4'd2;
            SEG_3:   bcd_o = 4'd3;
            SEG_4:   bcd_o = 4'd4;
            SEG_5:   bcd_o = 4'd5;
            SEG_6:   bcd_o = 4'd6;
            SEG_7:   bcd_o = 4'd7;
            SEG_8:   bcd_o = 4'd8;
            SEG_9:   bcd_o = 4'd9;
            default: invalid_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg7_scan_to_bcd.sv
// Recovers BCD digits from a multiplexed common-cathode 7-segment bus.
//
// Each digit position must present the same {strobe, segments} sample for
// STABLE_CYCLES consecutive registered samples before it is captured. Once
// every position has been captured, the whole frame is published.
//
// Ports:
//   clk_i     rising-edge clock
//   rst_i     synchronous active-high reset
//   seg_i     [6:0]             segment lines, abcdefg, active-high
//   dig_en_i  [NUM_DIGITS-1:0]  one-hot digit strobes, bit i = position i
//   bcd_o     [4*NUM_DIGITS-1:0] last complete frame, digit i at [4i+3:4i]
//   valid_o   one-cycle pulse in the cycle bcd_o takes a new frame
//   err_o     high with valid_o when any digit of that frame was unrecognised
//
// Output protocol: there is no back-pressure. valid_o is a single-cycle
// pulse qualifying bcd_o/err_o; bcd_o then holds until the next pulse and
// err_o is 0 whenever valid_o is 0.
module seg7_scan_to_bcd
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 3
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [6:0]              seg_i,
    input  logic [NUM_DIGITS-1:0]   dig_en_i,
    output logic [4*NUM_DIGITS-1:0] bcd_o,
    output logic                    valid_o,
    output logic                    err_o
);

    localparam int               SAMPLE_W   = NUM_DIGITS + 7;
    localparam logic [CNT_W-1:0] STABLE_CNT = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    // Input register and the previous registered sample used for the
    // stability comparison.
    logic [6:0]            seg_q;
    logic [NUM_DIGITS-1:0] dig_q;
    logic [SAMPLE_W-1:0]   prev_q;

    dwell_t dwell_q, dwell_d;

    logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
    logic [NUM_DIGITS-1:0]   seen_q, seen_d;
    logic [NUM_DIGITS-1:0]   bad_q, bad_d;

    logic [4*NUM_DIGITS-1:0] bcd_q, bcd_d;
    logic                    valid_q, valid_d;
    logic                    err_q, err_d;

    logic [3:0] dec_bcd;
    logic       dec_invalid;

    logic                  dig_onehot;
    logic                  same_sample;
    logic                  capture;
    logic [CNT_W-1:0]      count_inc;
    logic [NUM_DIGITS-1:0] cap_mask;

    seg7_pattern_decode u_decode (
        .seg_i     (seg_q),
        .bcd_o     (dec_bcd),
        .invalid_o (dec_invalid)
    );

    assign dig_onehot  = $onehot(dig_q);
    assign same_sample = ({dig_q, seg_q} == prev_q);
    assign count_inc   = (dwell_q.count == STABLE_CNT) ? dwell_q.count
                                                       : dwell_q.count + CNT_ONE;

    // Dwell FSM. The count tracks how many consecutive identical one-hot
    // samples have been seen; reaching STABLE_CNT captures and parks in
    // ST_HOLD so a long dwell captures only once.
    always_comb begin
        dwell_d = dwell_q;
        capture = 1'b0;
        case (dwell_q.state)
            ST_IDLE: begin
                if (dig_onehot) begin
                    dwell_d.state = ST_COUNT;
                    dwell_d.count = CNT_ONE;
                end else begin
                    dwell_d.count = '0;
                end
            end
            ST_COUNT, ST_HOLD: begin
                if (same_sample) begin
                    if (dwell_q.state == ST_COUNT) begin
                        dwell_d.count = count_inc;
                    end
                end else if (dig_onehot) begin
                    dwell_d.state = ST_COUNT;
                    dwell_d.count = CNT_ONE;
                end else begin
                    dwell_d.state = ST_IDLE;
                    dwell_d.count = '0;
                end
            end
            default: begin
                dwell_d.state = ST_IDLE;
                dwell_d.count = '0;
            end
        endcase
        // Checking the next count (not the current one) lets a first
        // one-hot sample capture immediately when STABLE_CYCLES is 1.
        if (dwell_d.state == ST_COUNT && dwell_d.count == STABLE_CNT) begin
            capture       = 1'b1;
            dwell_d.state = ST_HOLD;
        end
    end

    assign cap_mask = capture ? dig_q : '0;

    // Capture into the shadow frame, then publish when the capture fills
    // the last missing position.
    always_comb begin
        shadow_d = shadow_q;
        bad_d    = bad_q;
        seen_d   = seen_q | cap_mask;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (cap_mask[i]) begin
                shadow_d[4*i +: 4] = dec_bcd;
                bad_d[i]           = dec_invalid;
            end
        end
        bcd_d   = bcd_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        if (capture && (&seen_d)) begin
            bcd_d   = shadow_d;
            valid_d = 1'b1;
            err_d   = |bad_d;
            seen_d  = '0;
            bad_d   = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            seg_q    <= SEG_BLANK;
            dig_q    <= '0;
            prev_q   <= '0;
            dwell_q  <= '{state: ST_IDLE, count: '0};
            shadow_q <= '0;
            seen_q   <= '0;
            bad_q    <= '0;
            bcd_q    <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            seg_q    <= seg_i;
            dig_q    <= dig_en_i;
            prev_q   <= {dig_q, seg_q};
            dwell_q  <= dwell_d;
            shadow_q <= shadow_d;
            seen_q   <= seen_d;
            bad_q    <= bad_d;
            bcd_q    <= bcd_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
        end
    end

    assign bcd_o   = bcd_q;
    assign valid_o = valid_q;
    assign err_o   = err_q;

endmodule

// File: tb/tb_seg7_scan_to_bcd.sv
`timescale 1ns/1ps
module tb_seg7_scan_to_bcd;

    localparam int ND = 4;
    localparam int SC = 3;
    localparam int EW = 4*ND + 2;

    // ---------------- clock / reset / DUT ----------------
    logic          clk = 1'b0;
    logic          rst;
    logic [6:0]    seg;
    logic [ND-1:0] dig;
    logic [4*ND-1:0] bcd_o;
    logic          valid_o;
    logic          err_o;

    always #5 clk = ~clk;

    seg7_scan_to_bcd #(
        .NUM_DIGITS    (ND),
        .STABLE_CYCLES (SC)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .seg_i    (seg),
        .dig_en_i (dig),
        .bcd_o    (bcd_o),
        .valid_o  (valid_o),
        .err_o    (err_o)
    );

    // Legal patterns abcdefg for digits 0..9.
    logic [6:0] seg_tab [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                                 7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                                 7'b1111111, 7'b1111011};

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // The model keeps the history of registered samples and captures a
    // position when the trailing run of identical one-hot samples is exactly
    // SC long; frames are assembled with plain arrays.
    logic [ND+6:0]   hist_q [$];
    logic [EW-1:0]   exp_q  [$];
    logic [3:0]      m_shadow [ND];
    logic [ND-1:0]   m_seen;
    logic [ND-1:0]   m_bad;
    logic [4*ND-1:0] m_out_bcd;

    always @(posedge clk) begin : model
        logic [ND+6:0] cur;
        logic [EW-1:0] exp_w;
        int            run;
        int            pos;
        logic          done;
        logic [3:0]    d;
        logic          b;
        exp_w = '0;
        if (rst) begin
            for (int i = 0; i < ND; i++) m_shadow[i] = 4'h0;
            m_seen    = '0;
            m_bad     = '0;
            m_out_bcd = '0;
            hist_q.push_back('0);
        end else begin
            cur  = (hist_q.size() > 0) ? hist_q[hist_q.size()-1] : '0;
            run  = 0;
            done = 1'b0;
            for (int i = hist_q.size() - 1; i >= 0; i--) begin
                if (!done && hist_q[i] == cur) run++;
                else done = 1'b1;
            end
            exp_w[4*ND-1:0] = m_out_bcd;
            if ($countones(cur[ND+6:7]) == 1 && run == SC) begin
                pos = 0;
                for (int i = 0; i < ND; i++) if (cur[7+i]) pos = i;
                d = 4'hF;
                b = 1'b1;
                for (int v = 0; v < 10; v++) begin
                    if (seg_tab[v] == cur[6:0]) begin
                        d = 4'(v);
                        b = 1'b0;
                    end
                end
                m_shadow[pos] = d;
                m_bad[pos]    = b;
                m_seen[pos]   = 1'b1;
                if (&m_seen) begin
                    for (int i = 0; i < ND; i++) m_out_bcd[4*i +: 4] = m_shadow[i];
                    exp_w = {|m_bad, 1'b1, m_out_bcd};
                    m_seen = '0;
                    m_bad  = '0;
                end
            end
            hist_q.push_back({dig, seg});
        end
        while (hist_q.size() > SC + 2) void'(hist_q.pop_front());
        exp_q.push_back(exp_w);
    end

    // ---------------- scoreboard compare ----------------
    int              pulse_cnt = 0;
    logic [4*ND-1:0] last_bcd  = '0;
    logic            last_err  = 1'b0;

    always @(negedge clk) begin : compare
        logic [EW-1:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("bcd_o",   32'(bcd_o),   32'(e[4*ND-1:0]));
            check("valid_o", 32'(valid_o), 32'(e[4*ND]));
            check("err_o",   32'(err_o),   32'(e[4*ND+1]));
        end
        if (valid_o === 1'b1) begin
            pulse_cnt++;
            last_bcd = bcd_o;
            last_err = err_o;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic show(input int pos, input logic [6:0] code, input int n);
        dig = ND'(1) << pos;
        seg = code;
        repeat (n) @(negedge clk);
    endtask

    task automatic blank(input int n);
        dig = '0;
        seg = 7'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) @(negedge clk);
        rst = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    int base;

    initial begin
        rst = 1'b1;
        seg = 7'($urandom_range(0, 127));
        dig = ND'($urandom_range(0, 15));

        // Reset held two cycles with random inputs, then one cycle after release.
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            #1;
            check("rst_bcd",   32'(bcd_o),   32'h0);
            check("rst_valid", 32'(valid_o), 32'h0);
            check("rst_err",   32'(err_o),   32'h0);
            seg = 7'($urandom_range(0, 127));
            dig = ND'($urandom_range(0, 15));
        end
        rst = 1'b0;
        dig = '0;
        seg = 7'b0;
        @(negedge clk);
        #1;
        check("post_rst_bcd",   32'(bcd_o),   32'h0);
        check("post_rst_valid", 32'(valid_o), 32'h0);
        blank(1);

        // Normal scan 1,2,3,4.
        base = pulse_cnt;
        show(0, seg_tab[1], 4);
        show(1, seg_tab[2], 4);
        show(2, seg_tab[3], 4);
        show(3, seg_tab[4], 4);
        blank(3);
        #1;
        check("scan_pulses", 32'(pulse_cnt - base), 32'd1);
        check("scan_bcd",    32'(last_bcd), 32'h4321);
        check("scan_err",    32'(last_err), 32'h0);
        check("model_scan",  32'(m_out_bcd), 32'h4321);

        // Glitch: position 1 held only two cycles.
        base = pulse_cnt;
        show(0, seg_tab[5], 4);
        show(1, seg_tab[6], 2);
        show(2, seg_tab[7], 4);
        show(3, seg_tab[8], 4);
        blank(3);
        #1;
        check("glitch_no_pulse", 32'(pulse_cnt - base), 32'd0);
        show(1, seg_tab[6], 4);
        blank(3);
        #1;
        check("glitch_pulse", 32'(pulse_cnt - base), 32'd1);
        check("glitch_bcd",   32'(last_bcd), 32'h8765);

        // Unrecognised pattern on position 2.
        base = pulse_cnt;
        show(0, seg_tab[9], 4);
        show(1, seg_tab[0], 4);
        show(2, 7'b0000001, 4);
        show(3, seg_tab[1], 4);
        blank(3);
        #1;
        check("inv_pulse",  32'(pulse_cnt - base), 32'd1);
        check("inv_err",    32'(last_err), 32'h1);
        check("inv_nibble", 32'(last_bcd[11:8]), 32'hF);
        check("inv_bcd",    32'(last_bcd), 32'h1F09);

        // Multi-hot strobe never captures.
        base = pulse_cnt;
        dig = 4'b0011;
        seg = seg_tab[3];
        repeat (6) @(negedge clk);
        show(2, seg_tab[2], 4);
        show(3, seg_tab[3], 4);
        blank(3);
        #1;
        check("multihot_no_pulse", 32'(pulse_cnt - base), 32'd0);

        // Reset mid-frame discards the partial frame.
        do_reset(1);
        blank(1);
        base = pulse_cnt;
        show(0, seg_tab[9], 4);
        show(1, seg_tab[9], 4);
        show(2, seg_tab[9], 4);
        blank(1);
        do_reset(1);
        show(3, seg_tab[8], 4);
        blank(3);
        #1;
        check("rst_mid_no_pulse", 32'(pulse_cnt - base), 32'd0);
        show(0, seg_tab[5], 4);
        show(1, seg_tab[6], 4);
        show(2, seg_tab[7], 4);
        show(3, seg_tab[8], 4);
        blank(3);
        #1;
        check("rescan_pulse", 32'(pulse_cnt - base), 32'd1);
        check("rescan_bcd",   32'(last_bcd), 32'h8765);
        check("model_rescan", 32'(m_out_bcd), 32'h8765);

        // Randomised traffic checked against the model every cycle.
        repeat (400) begin
            int r;
            r = $urandom_range(0, 19);
            if (r == 0) begin
                do_reset($urandom_range(1, 2));
            end else if (r < 3) begin
                blank($urandom_range(1, 4));
            end else if (r < 5) begin
                logic [ND-1:0] m;
                do m = ND'($urandom_range(0, 15)); while ($countones(m) < 2);
                dig = m;
                seg = seg_tab[$urandom_range(0, 9)];
                repeat ($urandom_range(1, 6)) @(negedge clk);
            end else if ($urandom_range(0, 7) == 0) begin
                show($urandom_range(0, ND-1), 7'($urandom_range(0, 127)), $urandom_range(1, 5));
            end else begin
                show($urandom_range(0, ND-1), seg_tab[$urandom_range(0, 9)], $urandom_range(1, 5));
            end
        end
        blank(4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/seg7_scan_to_bcd.md
# seg7_scan_to_bcd

Recovers BCD digits from a time-multiplexed, common-cathode 7-segment display bus (segment lines plus one-hot digit strobes). It is the reader side of the BCD-to-7-segment decoder path and is used for display loop-back checking and panel capture. Each digit's pattern is filtered for stability and decoded back to BCD. The block publishes a complete frame with a one-cycle `valid_o` pulse once every digit position has been captured.

## Interface
- `NUM_DIGITS`, default 4: number of multiplexed digit positions; legal range 1–8.
- `STABLE_CYCLES`, default 3: consecutive identical samples required before a capture; legal range 1–15.

- `clk_i`  in  1  single clock; all logic on its rising edge.
- `rst_i`  in  1  reset, synchronous, active-high.
- `seg_i`  in  7  segment lines, active-high; bit6=a, bit5=b, bit4=c, bit3=d, bit2=e, bit1=f, bit0=g.
- `dig_en_i`  in  NUM_DIGITS  digit strobes, active-high; bit i selects digit position i.
- `bcd_o`  out  4*NUM_DIGITS  last complete frame; digit i occupies bits [4i+3:4i].
- `valid_o`  out  1  one-cycle pulse when `bcd_o` is updated.
- `err_o`  out  1  asserted together with `valid_o` when any digit in the frame was an unrecognised pattern; otherwise 0.

## Operation
- **Input register.** `seg_i` and `dig_en_i` are registered once (`seg_q`, `dig_q`). All further logic uses the registered values.
- **Legal codes (abcdefg).** Only these ten patterns decode to a digit:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011
  - 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011
  - Any other pattern decodes to 4'hF and is flagged invalid.
- **Dwell FSM** (`ST_IDLE`, `ST_COUNT`, `ST_HOLD`):
  - `ST_IDLE`: `dig_q` is zero (blanking) or not one-hot. The stability counter is held at 0. When `dig_q` becomes one-hot, go to `ST_COUNT` with count = 1.
  - `ST_COUNT`: if `{dig_q, seg_q}` equals the previous sample, count increments. On any change, a new one-hot value restarts at count = 1; a non-one-hot value returns to `ST_IDLE`.
  - Capture: when count reaches `STABLE_CYCLES`, the decoded digit is written to `shadow[i]`, `seen[i]` is set, `bad[i]` takes the invalid flag, and the FSM goes to `ST_HOLD`.
  - `ST_HOLD`: no further capture while the sample stays unchanged. A change goes to `ST_COUNT` (one-hot) or `ST_IDLE`.
  - With `STABLE_CYCLES` = 1, capture happens on the first one-hot sample.
- **Repeated capture.** Capturing a digit already marked in `seen` overwrites `shadow[i]` and `bad[i]`.
- **Frame completion.** In the cycle where `seen` (including the bit set by the current capture) becomes all-ones:
  - `bcd_o` is loaded from `shadow`, including the current capture.
  - `valid_o` = 1 and `err_o` = OR of `bad`, including the current capture.
  - `seen` and `bad` are cleared.
- **Reset.** Reset clears all state at any time. A partial frame is discarded and is never published.

## Timing
- Reset values:
  - `bcd_o` = 0, `valid_o` = 0, `err_o` = 0
  - `seen` = 0, `bad` = 0, `shadow` = 0
  - count = 0, FSM = `ST_IDLE`, `seg_q` = 0, `dig_q` = 0
- Capture latency: an input held across rising edges k … k+`STABLE_CYCLES`−1 is sampled into `seg_q`/`dig_q` at those edges. The capture into `shadow` happens at edge k+`STABLE_CYCLES`.
- Output update: when that capture completes a frame, `bcd_o`/`valid_o`/`err_o` are registered at that same edge and are visible for exactly one cycle.
- `valid_o` and `err_o` are never high in consecutive cycles unless `NUM_DIGITS` = 1.
- The count saturates at `STABLE_CYCLES`. It is 4 bits wide.
- A multi-hot strobe held for any length of time never causes a capture.

## Structure
- Shared package `seg7_pkg` holds:
  - `SEG_0` … `SEG_9` constants
  - `SEG_BLANK` = 7'b0
  - the `dwell_state_t` enum
  - these are shared with the existing BCD-to-7-segment decoder.
- Sub-module `seg7_pattern_decode`: combinational; `seg` [6:0] → `bcd` [3:0], `invalid`. It is instantiated once on `seg_q`.
- Top module contains the input register, dwell FSM, `shadow`/`seen`/`bad` arrays and the output register.

## Test plan
- **Reset:** hold `rst_i` = 1 for 2 cycles with random inputs → `bcd_o` = 0, `valid_o` = 0, `err_o` = 0 throughout and one cycle after release.
- **Normal scan:** scan digits 1, 2, 3, 4 on positions 0–3, each held 4 cycles (`STABLE_CYCLES` = 3) → exactly one `valid_o` pulse, `bcd_o` = 16'h4321, `err_o` = 0.
- **Glitch filter:** position 1 held only 2 cycles within an otherwise normal scan → no `valid_o` until position 1 is later held for ≥3 cycles.
- **Invalid pattern:** position 2 shows 0000001 (all other positions legal) → `valid_o` = 1, `err_o` = 1, `bcd_o`[11:8] = 4'hF.
- **Multi-hot strobe:** `dig_en_i` = 4'b0011 held 6 cycles, then positions 2 and 3 scanned → no capture for positions 0/1 and no `valid_o`.
- **Reset mid-frame:** positions 0–2 captured, `rst_i` pulsed, then only position 3 scanned → no `valid_o`; a full rescan of 5, 6, 7, 8 then yields `bcd_o` = 16'h8765.
